// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - byte-stream loader writing sprite palette and image BRAMs
module sprite_loader #(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 512,
    parameter int PAL_DEPTH = 256
) (
    input  logic                            pixel_clk_in,
    input  logic                            rst_n_in,
    input  logic [7:0]                      byte_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  logic                            abort_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] img_addr_out,
    output logic [7:0]                      img_data_out,
    output logic                            img_we_out,
    output logic [$clog2(PAL_DEPTH)-1:0]    pal_addr_out,
    output logic [23:0]                     pal_data_out,
    output logic                            pal_we_out,
    output logic                            done_out,
    output logic                            err_out
);
    localparam int AW        = $clog2(WIDTH*HEIGHT);
    localparam int PW        = $clog2(PAL_DEPTH);
    localparam int FRAME_PIX = WIDTH*(HEIGHT/2);

    localparam logic [AW-1:0] LAST_PIX    = AW'(FRAME_PIX-1);
    localparam logic [AW-1:0] FRAME1_BASE = AW'(FRAME_PIX);
    localparam logic [PW-1:0] LAST_ENTRY  = PW'(PAL_DEPTH-1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_PAL   = 8'h01;
    localparam logic [7:0] CMD_IMG0  = 8'h02;
    localparam logic [7:0] CMD_IMG1  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAL,
        S_IMG,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          ready_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] pix_cnt_q;
    logic [PW-1:0] entry_q;
    logic [1:0]    phase_q;
    logic [7:0]    r_q;
    logic [7:0]    g_q;

    logic [AW-1:0] img_addr_q;
    logic [7:0]    img_data_q;
    logic          img_we_q;
    logic [PW-1:0] pal_addr_q;
    logic [23:0]   pal_data_q;
    logic          pal_we_q;
    logic          done_q;
    logic          err_q;

    logic          accept;
    logic [AW-1:0] img_addr_d;
    logic [AW-1:0] pix_cnt_d;
    logic [PW-1:0] entry_d;
    logic [23:0]   pal_data_d;

    assign accept = valid_in && ready_q;

    always_comb begin
        img_addr_d = base_q + pix_cnt_q;
        pix_cnt_d  = pix_cnt_q + AW'(1);
        entry_d    = entry_q + PW'(1);
        pal_data_d = {r_q, g_q, byte_in};
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            base_q     <= '0;
            pix_cnt_q  <= '0;
            entry_q    <= '0;
            phase_q    <= 2'd0;
            r_q        <= '0;
            g_q        <= '0;
            img_addr_q <= '0;
            img_data_q <= '0;
            img_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
            pal_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            img_we_q <= 1'b0;
            pal_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;

            // Abort drops any byte accepted this cycle; a write already on the outputs still completes.
            if (abort_in) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept && byte_in == SYNC_BYTE) begin
                            state_q <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (accept) begin
                            if (byte_in == CMD_PAL) begin
                                state_q <= S_PAL;
                                entry_q <= '0;
                                phase_q <= 2'd0;
                            end else if (byte_in == CMD_IMG0 || byte_in == CMD_IMG1) begin
                                state_q   <= S_IMG;
                                base_q    <= byte_in[0] ? FRAME1_BASE : '0;
                                pix_cnt_q <= '0;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_PAL: begin
                        if (accept) begin
                            case (phase_q)
                                2'd0: begin
                                    r_q     <= byte_in;
                                    phase_q <= 2'd1;
                                end
                                2'd1: begin
                                    g_q     <= byte_in;
                                    phase_q <= 2'd2;
                                end
                                default: begin
                                    pal_we_q   <= 1'b1;
                                    pal_addr_q <= entry_q;
                                    pal_data_q <= pal_data_d;
                                    phase_q    <= 2'd0;
                                    entry_q    <= entry_d;
                                    if (entry_q == LAST_ENTRY) begin
                                        state_q <= S_DONE;
                                    end
                                end
                            endcase
                        end
                    end
                    S_IMG: begin
                        if (accept) begin
                            img_we_q   <= 1'b1;
                            img_addr_q <= img_addr_d;
                            img_data_q <= byte_in;
                            pix_cnt_q  <= pix_cnt_d;
                            if (pix_cnt_q == LAST_PIX) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        // The last write is on the outputs this cycle; a byte offered now is parsed as from IDLE.
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= (accept && byte_in == SYNC_BYTE) ? S_CMD : S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ready_out    = ready_q;
    assign img_addr_out = img_addr_q;
    assign img_data_out = img_data_q;
    assign img_we_out   = img_we_q;
    assign pal_addr_out = pal_addr_q;
    assign pal_data_out = pal_data_q;
    assign pal_we_out   = pal_we_q;
    assign done_out     = done_q;
    assign err_out      = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - directed self-checking bench for sprite_loader
module tb_sprite_loader;
    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        valid_in;
    logic        ready_out;
    logic        abort_in;
    logic [3:0]  img_addr_out;
    logic [7:0]  img_data_out;
    logic        img_we_out;
    logic [1:0]  pal_addr_out;
    logic [23:0] pal_data_out;
    logic        pal_we_out;
    logic        done_out;
    logic        err_out;

    sprite_loader #(.WIDTH(4), .HEIGHT(4), .PAL_DEPTH(4)) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .byte_in      (byte_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .abort_in     (abort_in),
        .img_addr_out (img_addr_out),
        .img_data_out (img_data_out),
        .img_we_out   (img_we_out),
        .pal_addr_out (pal_addr_out),
        .pal_data_out (pal_data_out),
        .pal_we_out   (pal_we_out),
        .done_out     (done_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int img_a_log[$];
    int img_d_log[$];
    int img_c_log[$];
    int pal_a_log[$];
    int pal_d_log[$];
    int done_cnt;
    int done_cyc;
    int err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (img_we_out) begin
            img_a_log.push_back(int'(img_addr_out));
            img_d_log.push_back(int'(img_data_out));
            img_c_log.push_back(cyc);
        end
        if (pal_we_out) begin
            pal_a_log.push_back(int'(pal_addr_out));
            pal_d_log.push_back(int'(pal_data_out));
        end
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
            check("ready_in_done", 32'(ready_out), 32'd0);
        end
        if (err_out) err_cnt++;
    end

    task automatic clear_logs();
        img_a_log.delete();
        img_d_log.delete();
        img_c_log.delete();
        pal_a_log.delete();
        pal_d_log.delete();
        done_cnt = 0;
        done_cyc = -1;
        err_cnt  = 0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        abort_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ab);
        int n;
        n = 0;
        byte_in  = b;
        valid_in = 1'b1;
        abort_in = ab;
        @(negedge clk);
        while (!ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(ready_out), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_img(input logic [7:0] cmd, input int d0, input bit gaps);
        send_byte(8'hA5, 1'b0);
        send_byte(cmd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(d0 + i), 1'b0);
            if (gaps) idle(1);
        end
        idle(4);
    endtask

    task automatic check_img(input string tag, input int n, input int a0, input int d0, input int step);
        check({tag, "_count"}, 32'(img_a_log.size()), 32'(n));
        for (int i = 0; i < n && i < img_a_log.size(); i++) begin
            check({tag, "_addr"}, 32'(img_a_log[i]), 32'(a0 + i));
            check({tag, "_data"}, 32'(img_d_log[i]), 32'(d0 + i));
            if (i > 0) check({tag, "_spacing"}, 32'(img_c_log[i] - img_c_log[i-1]), 32'(step));
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_ready"},   32'(ready_out),    32'd0);
        check({tag, "_img_we"},  32'(img_we_out),   32'd0);
        check({tag, "_img_addr"}, 32'(img_addr_out), 32'd0);
        check({tag, "_img_data"}, 32'(img_data_out), 32'd0);
        check({tag, "_pal_we"},  32'(pal_we_out),   32'd0);
        check({tag, "_pal_data"}, 32'(pal_data_out), 32'd0);
        check({tag, "_done"},    32'(done_out),     32'd0);
        check({tag, "_err"},     32'(err_out),      32'd0);
    endtask

    logic [7:0]  pal_bytes [12];
    logic [23:0] pal_exp [4];

    initial begin
        rst_n    = 1'b0;
        byte_in  = 8'h00;
        valid_in = 1'b0;
        abort_in = 1'b0;
        clear_logs();

        // Reset state, then ready rises on the first edge after release
        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(ready_out), 32'd1);
        idle(1);

        // Frame 0, back-to-back
        clear_logs();
        send_img(8'h02, 8'h10, 1'b0);
        check_img("f0", 8, 0, 8'h10, 1);
        check("f0_done_cnt", 32'(done_cnt), 32'd1);
        if (img_c_log.size() == 8) check("f0_done_timing", 32'(done_cyc), 32'(img_c_log[7] + 1));
        check("f0_err", 32'(err_cnt), 32'd0);
        check("f0_pal_writes", 32'(pal_a_log.size()), 32'd0);

        // Frame 1 with valid gaps
        clear_logs();
        send_img(8'h03, 8'h20, 1'b1);
        check_img("f1", 8, 8, 8'h20, 2);
        check("f1_done_cnt", 32'(done_cnt), 32'd1);

        // Palette load
        clear_logs();
        pal_bytes = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                      8'h00, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33};
        pal_exp   = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h112233};
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 12; i++) send_byte(pal_bytes[i], 1'b0);
        idle(4);
        check("pal_count", 32'(pal_a_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < pal_a_log.size(); i++) begin
            check("pal_addr", 32'(pal_a_log[i]), 32'(i));
            check("pal_data", 32'(pal_d_log[i]), 32'(pal_exp[i]));
        end
        check("pal_img_writes", 32'(img_a_log.size()), 32'd0);
        check("pal_done_cnt", 32'(done_cnt), 32'd1);

        // Junk, then a bad command
        clear_logs();
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        idle(4);
        check("bad_err_cnt", 32'(err_cnt), 32'd1);
        check("bad_img_writes", 32'(img_a_log.size()), 32'd0);
        check("bad_pal_writes", 32'(pal_a_log.size()), 32'd0);
        check("bad_done_cnt", 32'(done_cnt), 32'd0);
        clear_logs();
        send_img(8'h02, 8'h30, 1'b0);
        check_img("after_bad", 8, 0, 8'h30, 1);
        check("after_bad_done", 32'(done_cnt), 32'd1);

        // Abort on the fourth payload byte
        clear_logs();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b1);
        idle(4);
        check_img("abort", 3, 0, 8'h40, 1);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        clear_logs();
        send_img(8'h02, 8'h50, 1'b0);
        check_img("after_abort", 8, 0, 8'h50, 1);
        check("after_abort_done", 32'(done_cnt), 32'd1);

        // Reset in the middle of an image packet
        clear_logs();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h60, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        check("pre_reset_we", 32'(img_we_out), 32'd1);
        check("pre_reset_addr", 32'(img_addr_out), 32'd2);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_quiet_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst2_ready_before_edge", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        check("rst2_ready_after_release", 32'(ready_out), 32'd1);
        idle(1);
        clear_logs();
        send_img(8'h02, 8'h70, 1'b0);
        check_img("after_rst", 8, 0, 8'h70, 1);
        check("after_rst_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
